// File: rtl/alzette_ise_seq_if.sv
// Request/response bundle between the core's multi-cycle execute stage and the Alzette unit.
// The core is the master: it drives the request and consumes rd.
interface alzette_ise_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  imm;
  logic        op_x;
  logic        op_enc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rd;

  modport master (
    output in_valid, rs1, rs2, imm, op_x, op_enc, out_ready,
    input  in_ready, out_valid, rd
  );

  modport slave (
    input  in_valid, rs1, rs2, imm, op_x, op_enc, out_ready,
    output in_ready, out_valid, rd
  );
endinterface

// File: rtl/alzette_ise_seq.sv
// Sequential Alzette ARX-box (encrypt or inverse) for the rv32 Sparkle ISE.
// QPC quarters are evaluated per BUSY cycle; a one-entry cache serves the partner word of a pair.
module alzette_ise_seq #(
  parameter int   QPC   = 4,
  parameter logic DEC_E = 1'b1,
  parameter logic CACHE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  alzette_ise_seq_if.slave   bus
);

  if (QPC != 1 && QPC != 2 && QPC != 4) begin : g_bad_qpc
    $error("alzette_ise_seq: QPC must be 1, 2 or 4");
  end

  localparam int         NCYC = 4 / QPC;
  localparam logic [1:0] LAST = 2'(NCYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] rotr(input logic [31:0] v, input logic [4:0] r);
    logic [63:0] t;
    t = {v, v} >> r;
    return t[31:0];
  endfunction

  function automatic logic [31:0] round_const(input logic [2:0] i);
    case (i)
      3'd0:    return 32'hB7E15162;
      3'd1:    return 32'hBF715880;
      3'd2:    return 32'h38B4DA56;
      3'd3:    return 32'h324E7738;
      3'd4:    return 32'hBB1185EB;
      3'd5:    return 32'h4F7C7B57;
      3'd6:    return 32'hCFBFA1C8;
      3'd7:    return 32'hC2B3293D;
      default: return 32'h00000000;
    endcase
  endfunction

  function automatic logic [4:0] rot_r(input logic [1:0] q);
    case (q)
      2'd0:    return 5'd31;
      2'd1:    return 5'd17;
      2'd2:    return 5'd0;
      2'd3:    return 5'd24;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] rot_s(input logic [1:0] q);
    case (q)
      2'd0:    return 5'd24;
      2'd1:    return 5'd17;
      2'd2:    return 5'd31;
      2'd3:    return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

  // The inverse walks the same quarter index upward but uses the rotations of quarter 3-q.
  function automatic logic [63:0] quarter(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] c, input logic [1:0] q,
                                          input logic enc);
    logic [31:0] xa;
    logic [31:0] ya;
    logic [1:0]  qd;
    qd = 2'd3 - q;
    if (enc) begin
      xa = x + rotr(y, rot_r(q));
      ya = y ^ rotr(xa, rot_s(q));
      xa = xa ^ c;
    end else begin
      xa = x ^ c;
      ya = y ^ rotr(xa, rot_s(qd));
      xa = xa - rotr(ya, rot_r(qd));
    end
    return {xa, ya};
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [1:0]  counter_r;
  logic [31:0] x_r;
  logic [31:0] y_r;
  logic [31:0] c_r;
  logic        enc_r;
  logic        op_x_r;
  logic [67:0] key_r;
  logic [31:0] rd_r;
  logic        out_valid_r;
  logic        in_ready_r;
  logic        cache_valid_r;
  logic [67:0] cache_key_r;
  logic [31:0] cache_x_r;
  logic [31:0] cache_y_r;

  logic        op_enc_eff_s;
  logic [67:0] req_key_s;
  logic        hit_s;
  logic        accept_s;
  logic        hit_take_s;
  logic        finish_s;
  logic [63:0] xy_s;

  assign op_enc_eff_s = bus.op_enc | ~DEC_E;
  assign req_key_s    = {bus.rs1, bus.rs2, bus.imm, op_enc_eff_s};
  assign hit_s        = CACHE && cache_valid_r && (cache_key_r == req_key_s);

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.rd        = rd_r;

  // Combinational chain of QPC quarters starting at quarter counter*QPC.
  always_comb begin
    xy_s = {x_r, y_r};
    for (int k = 0; k < QPC; k++) begin
      xy_s = quarter(xy_s[63:32], xy_s[31:0], c_r, 2'(int'(counter_r) * QPC + k), enc_r);
    end
  end

  // Next-state decode and the one-cycle control strobes.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    hit_take_s   = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          if (hit_s) begin
            state_next_s = DONE;
            hit_take_s   = 1'b1;
          end else begin
            state_next_s = BUSY;
            accept_s     = 1'b1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (counter_r == LAST) begin
          state_next_s = DONE;
          finish_s     = 1'b1;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, operand latches, result register and result cache.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      counter_r     <= 2'd0;
      x_r           <= 32'd0;
      y_r           <= 32'd0;
      c_r           <= 32'd0;
      enc_r         <= 1'b1;
      op_x_r        <= 1'b0;
      key_r         <= 68'd0;
      rd_r          <= 32'd0;
      out_valid_r   <= 1'b0;
      in_ready_r    <= 1'b1;
      cache_valid_r <= 1'b0;
      cache_key_r   <= 68'd0;
      cache_x_r     <= 32'd0;
      cache_y_r     <= 32'd0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
      if (accept_s) begin
        x_r       <= bus.rs1;
        y_r       <= bus.rs2;
        c_r       <= round_const(bus.imm);
        enc_r     <= op_enc_eff_s;
        op_x_r    <= bus.op_x;
        key_r     <= req_key_s;
        counter_r <= 2'd0;
      end else if (state_r == BUSY) begin
        x_r       <= xy_s[63:32];
        y_r       <= xy_s[31:0];
        counter_r <= counter_r + 2'd1;
      end
      if (hit_take_s) begin
        rd_r <= bus.op_x ? cache_x_r : cache_y_r;
      end else if (finish_s) begin
        rd_r <= op_x_r ? xy_s[63:32] : xy_s[31:0];
        if (CACHE) begin
          cache_valid_r <= 1'b1;
          cache_key_r   <= key_r;
          cache_x_r     <= xy_s[63:32];
          cache_y_r     <= xy_s[31:0];
        end
      end
    end
  end

endmodule
